// File: rtl/mem_port_pkg.sv
// Shared types and constants for the main memory port: FSM states,
// request-type encodings and the wait-state counter width.
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam logic MRW_READ  = 1'b0;
  localparam logic MRW_WRITE = 1'b1;

  localparam int CNT_W = 8;

endpackage : mem_port_pkg

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered, enable-gated read port.
// The read register is resettable so the port's read data has a defined reset value.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_array

// File: rtl/main_memory_port.sv
// Memory-side port and backing store: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then commits the write or returns read data with MReady.
module main_memory_port
  import mem_port_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
  output logic              Busy,
  output logic              Overrun
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic              commit;
  logic              ram_rw;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    commit    = 1'b0;
    overrun_d = overrun_q | (MStrobe && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (MStrobe) begin
          addr_d = MAddr;
          data_d = MDataIn;
          rw_d   = MRW;
          cnt_d  = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            commit  = 1'b1;
            state_d = XFER;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          commit  = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == XFER);
    busy_d  = (state_d != IDLE);
  end

  // With zero wait states the commit happens on the accepting edge, so the
  // RAM must see the live request rather than the (not yet loaded) registers.
  always_comb begin
    ram_addr  = (state_q == IDLE) ? MAddr   : addr_q;
    ram_wdata = (state_q == IDLE) ? MDataIn : data_q;
    ram_rw    = (state_q == IDLE) ? MRW     : rw_q;
    ram_we    = commit && (ram_rw == MRW_WRITE) && !reset;
    ram_re    = commit && (ram_rw == MRW_READ)  && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= MRW_READ;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .reset_i (reset),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (MDataOut)
  );

  assign MReady  = ready_q;
  assign Busy    = busy_q;
  assign Overrun = overrun_q;

endmodule : main_memory_port
